// File: rtl/data_ram_pkg.sv
// data_ram_pkg: shared definitions for data_ram_1r1w_p.
//   CLEAR/RUN  sequencer state encodings
//   rd_lat_ok  legal read-latency check (1 or 2)
//   data_w     word width from lane count and lane width
package data_ram_pkg;
  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] RUN = 1'b1;
  function automatic bit rd_lat_ok(input int lat);
    return lat == 1 || lat == 2;
  endfunction
  function automatic int data_w(input int nlane, input int lw);
    return nlane * lw;
  endfunction
endpackage

// File: rtl/data_ram_if.sv
// data_ram_if: LSU <-> data RAM bus.
//   master (LSU): drives clr_req, ram_ren/ram_radr, ram_wadr/ram_wdata/ram_wen;
//                 receives ram_ready, ram_rdata/ram_rvld, ram_wdrop
//   slave (RAM):  the mirror image
interface data_ram_if #(
  parameter int AW = 12,
  parameter int NLANE = 4,
  parameter int LW = 8
);
  import data_ram_pkg::*;
  localparam int DW = data_w(NLANE, LW);
  logic clr_req, ram_ready, ram_ren, ram_rvld, ram_wdrop;
  logic [AW-1:0] ram_radr, ram_wadr;
  logic [DW-1:0] ram_rdata, ram_wdata;
  logic [NLANE-1:0] ram_wen;
  modport master (
    output clr_req, ram_ren, ram_radr, ram_wadr, ram_wdata, ram_wen,
    input ram_ready, ram_rdata, ram_rvld, ram_wdrop
  );
  modport slave (
    input clr_req, ram_ren, ram_radr, ram_wadr, ram_wdata, ram_wen,
    output ram_ready, ram_rdata, ram_rvld, ram_wdrop
  );
endinterface

// File: rtl/data_ram_1r1w_p_lane.sv
// ram_lane_1r1w: one LW-bit x 2**AW lane, synchronous write, registered read.
//   clk, rst_n      clock, async active-low reset (read register only)
//   we/wadr/wdata   write port
//   re/radr/rdata   read port; rdata updates only when re, otherwise holds
// The read register samples the array before the same-edge write lands,
// so a colliding read sees the old contents (read-first).
module ram_lane_1r1w
  import data_ram_pkg::*;
#(
  parameter int AW = 12,
  parameter int LW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] wadr,
  input  logic [LW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] radr,
  output logic [LW-1:0] rdata
);
  logic [LW-1:0] mem [2**AW];
  always_ff @(posedge clk)
    if (we) mem[wadr] <= wdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdata <= '0;
    else if (re) rdata <= mem[radr];
endmodule

// File: rtl/data_ram_1r1w_p.sv
// data_ram_1r1w_p: byte-lane 1R1W data RAM with clear sequencer and 1/2-cycle read latency.
//   clk, rst_n  clock, async active-low reset
//   bus         data_ram_if.slave (clear request, ready, read, write, write-drop)
// Optional read-during-write bypass (write-first per lane) when DATA_RAM_BYPASS_EN is defined;
// otherwise a colliding read returns the old word.
module data_ram_1r1w_p
  import data_ram_pkg::*;
#(
  parameter int AW = 12,
  parameter int NLANE = 4,
  parameter int LW = 8,
  parameter int RD_LAT = 1
) (
  input logic clk,
  input logic rst_n,
  data_ram_if.slave bus
);
  localparam int DW = data_w(NLANE, LW);
  if (!rd_lat_ok(RD_LAT)) begin : g_bad_lat
    $error("data_ram_1r1w_p: RD_LAT must be 1 or 2");
  end
  logic [0:0] state;
  logic [AW-1:0] clr_cnt;
  logic clearing, acc, rvld1;
  logic [NLANE-1:0] we;
  logic [AW-1:0] wadr;
  logic [DW-1:0] wdata, lane_q, rd1;
  assign clearing = state == CLEAR;
  assign bus.ram_ready = state == RUN;
  assign acc = bus.ram_ren & bus.ram_ready;
  // The clear sequencer owns the write port while clearing; user writes are dropped.
  assign we = clearing ? '1 : bus.ram_wen;
  assign wadr = clearing ? clr_cnt : bus.ram_wadr;
  assign wdata = clearing ? '0 : bus.ram_wdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= CLEAR;
      clr_cnt <= '0;
    end else if (clearing) begin
      clr_cnt <= clr_cnt + 1'b1;
      if (&clr_cnt) state <= RUN;
    end else if (bus.clr_req) begin
      state <= CLEAR;
      clr_cnt <= '0;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rvld1 <= 1'b0;
      bus.ram_wdrop <= 1'b0;
    end else begin
      rvld1 <= acc;
      bus.ram_wdrop <= clearing & |bus.ram_wen;
    end
  for (genvar i = 0; i < NLANE; i++) begin : g_lane
    ram_lane_1r1w #(.AW(AW), .LW(LW)) u_lane (
      .clk(clk),
      .rst_n(rst_n),
      .we(we[i]),
      .wadr(wadr),
      .wdata(wdata[i*LW +: LW]),
      .re(acc),
      .radr(bus.ram_radr),
      .rdata(lane_q[i*LW +: LW])
    );
  end
`ifdef DATA_RAM_BYPASS_EN
  // Captured only on an accepted read so the merged word holds with the lane registers.
  logic [NLANE-1:0] byp_wen;
  logic [DW-1:0] byp_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      byp_wen <= '0;
      byp_data <= '0;
    end else if (acc) begin
      byp_wen <= bus.ram_radr == bus.ram_wadr ? bus.ram_wen : '0;
      byp_data <= bus.ram_wdata;
    end
  always_comb begin
    rd1 = lane_q;
    for (int i = 0; i < NLANE; i++)
      rd1[i*LW +: LW] = byp_wen[i] ? byp_data[i*LW +: LW] : lane_q[i*LW +: LW];
  end
`else
  assign rd1 = lane_q;
`endif
  if (RD_LAT == 2) begin : g_lat2
    logic rvld2;
    logic [DW-1:0] out_q;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        rvld2 <= 1'b0;
        out_q <= '0;
      end else begin
        rvld2 <= rvld1;
        if (rvld1) out_q <= rd1;
      end
    assign bus.ram_rvld = rvld2;
    assign bus.ram_rdata = out_q;
  end else begin : g_lat1
    assign bus.ram_rvld = rvld1;
    assign bus.ram_rdata = rd1;
  end
endmodule

// File: tb/tb_data_ram_1r1w_p.sv
// tb_data_ram_1r1w_p: drives one stimulus stream into RD_LAT=1 and RD_LAT=2 instances and scoreboards both.
module tb_data_ram_1r1w_p;
  localparam int AW = 12, NL = 4, LW = 8;
  typedef struct { logic [31:0] data; int due; } item_t;
  typedef struct {
    logic ren; logic [AW-1:0] radr; logic [3:0] wen; logic [AW-1:0] wadr; logic [31:0] wdata; logic [31:0] exp;
  } vec_t;
`ifdef DATA_RAM_BYPASS_EN
  localparam logic [31:0] RAW_EXP = 32'h11112222;
`else
  localparam logic [31:0] RAW_EXP = 32'h11111111;
`endif
  logic clk = 0, rst_n = 1;
  logic clr_req = 0, ren = 0;
  logic [AW-1:0] radr = 0, wadr = 0;
  logic [31:0] wdata = 0;
  logic [3:0] wen = 0;
  data_ram_if #(.AW(AW), .NLANE(NL), .LW(LW)) b0 (), b1 ();
  assign b0.clr_req = clr_req; assign b1.clr_req = clr_req;
  assign b0.ram_ren = ren; assign b1.ram_ren = ren;
  assign b0.ram_radr = radr; assign b1.ram_radr = radr;
  assign b0.ram_wadr = wadr; assign b1.ram_wadr = wadr;
  assign b0.ram_wdata = wdata; assign b1.ram_wdata = wdata;
  assign b0.ram_wen = wen; assign b1.ram_wen = wen;
  data_ram_1r1w_p #(.AW(AW), .NLANE(NL), .LW(LW), .RD_LAT(1)) u_lat1 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
  data_ram_1r1w_p #(.AW(AW), .NLANE(NL), .LW(LW), .RD_LAT(2)) u_lat2 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  always #5 clk = ~clk;
  logic [31:0] mem [4096];
  bit m_run = 0, m_wdrop = 0;
  int m_cnt = 0, cyc = 0, errs = 0, checks = 0;
  logic [31:0] m_rdata [2] = '{32'h0, 32'h0};
  item_t sbq [2][$];
  vec_t tv [16];
  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s dut%0d @cyc %0d: got %h expected %h", nm, d, cyc, act, exp);
    end
  endtask
  task automatic do_reset();
    rst_n = 0;
    m_run = 0; m_cnt = 0; m_wdrop = 0;
    m_rdata[0] = 0; m_rdata[1] = 0;
    sbq[0].delete(); sbq[1].delete();
    #20 rst_n = 1;
  endtask
  task automatic step(input bit use_ovr = 0, input logic [31:0] ovr = 0);
    logic [31:0] e;
    @(posedge clk);
    cyc++;
    e = mem[radr];
`ifdef DATA_RAM_BYPASS_EN
    if (radr == wadr) for (int i = 0; i < 4; i++) if (wen[i]) e[i*8 +: 8] = wdata[i*8 +: 8];
`endif
    if (use_ovr) e = ovr;
    if (ren && m_run) begin
      sbq[0].push_back('{e, cyc});
      sbq[1].push_back('{e, cyc + 1});
    end
    m_wdrop = !m_run && |wen;
    if (m_run) begin
      for (int i = 0; i < 4; i++) if (wen[i]) mem[wadr][i*8 +: 8] = wdata[i*8 +: 8];
      if (clr_req) begin m_run = 0; m_cnt = 0; end
    end else begin
      mem[m_cnt] = 0;
      if (m_cnt == 4095) begin m_run = 1; m_cnt = 0; end
      else m_cnt++;
    end
    #1;
  endtask
  task automatic idle();
    ren = 0; wen = 0; clr_req = 0;
  endtask
  task automatic wait_ready(input string nm, input int exp_n);
    int n = 0;
    while (!b0.ram_ready && n < 5000) begin step(); n++; end
    chk(nm, 0, n, exp_n);
  endtask
  always @(negedge clk) begin
    logic rdy, wd, rv;
    logic [31:0] rd;
    item_t it;
    for (int d = 0; d < 2; d++) begin
      rdy = d ? b1.ram_ready : b0.ram_ready;
      wd = d ? b1.ram_wdrop : b0.ram_wdrop;
      rv = d ? b1.ram_rvld : b0.ram_rvld;
      rd = d ? b1.ram_rdata : b0.ram_rdata;
      chk("ready", d, rdy, m_run);
      chk("wdrop", d, wd, m_wdrop);
      if (sbq[d].size() > 0 && sbq[d][0].due == cyc) begin
        it = sbq[d].pop_front();
        chk("rvld", d, rv, 1);
        chk("rdata", d, rd, it.data);
        m_rdata[d] = it.data;
      end else begin
        chk("rvld_idle", d, rv, 0);
        chk("rdata_hold", d, rd, m_rdata[d]);
      end
    end
  end
  initial begin
    tv[0]  = '{1, 12'h000, 4'h0, 12'h000, 32'h0, 32'h0};
    tv[1]  = '{1, 12'h7FF, 4'h0, 12'h000, 32'h0, 32'h0};
    tv[2]  = '{1, 12'hFFF, 4'h0, 12'h000, 32'h0, 32'h0};
    tv[3]  = '{0, 12'h000, 4'b0101, 12'h010, 32'hAABBCCDD, 32'h0};
    tv[4]  = '{1, 12'h010, 4'h0, 12'h000, 32'h0, 32'h00BB00DD};
    tv[5]  = '{0, 12'h000, 4'b1010, 12'h010, 32'hAABBCCDD, 32'h0};
    tv[6]  = '{1, 12'h010, 4'h0, 12'h000, 32'h0, 32'hAABBCCDD};
    tv[7]  = '{0, 12'h000, 4'hF, 12'h020, 32'h11111111, 32'h0};
    tv[8]  = '{1, 12'h020, 4'b0011, 12'h020, 32'h22222222, RAW_EXP};
    tv[9]  = '{1, 12'h020, 4'h0, 12'h000, 32'h0, 32'h11112222};
    tv[10] = '{0, 12'h000, 4'hF, 12'h001, 32'h00000001, 32'h0};
    tv[11] = '{0, 12'h000, 4'hF, 12'h002, 32'h00000002, 32'h0};
    tv[12] = '{0, 12'h000, 4'hF, 12'h003, 32'h00000003, 32'h0};
    tv[13] = '{1, 12'h001, 4'h0, 12'h000, 32'h0, 32'h00000001};
    tv[14] = '{1, 12'h002, 4'h0, 12'h000, 32'h0, 32'h00000002};
    tv[15] = '{1, 12'h003, 4'h0, 12'h000, 32'h0, 32'h00000003};
    #2;
    do_reset();
    chk("reset_rdata", 0, b0.ram_rdata, 0);
    wait_ready("reset_clear_len", 4096);
    foreach (tv[i]) begin
      ren = tv[i].ren; radr = tv[i].radr; wen = tv[i].wen; wadr = tv[i].wadr; wdata = tv[i].wdata;
      step(tv[i].ren, tv[i].exp);
    end
    idle();
    repeat (3) step();
    for (int i = 0; i < 400; i++) begin
      ren = 1'($urandom_range(0, 1)); radr = 12'($urandom_range(0, 15));
      wen = 4'($urandom_range(0, 15)); wadr = 12'($urandom_range(0, 15)); wdata = $urandom;
      step();
    end
    idle();
    wen = 4'hF; wadr = 12'h005; wdata = 32'h12345678;
    step();
    ren = 1; radr = 12'h005; wdata = 32'hDEADBEEF; clr_req = 1;
    step();
    clr_req = 0;
    repeat (3) step();
    idle();
    step();
    wait_ready("clr_req_clear_len", 4092);
    ren = 1; radr = 12'h005;
    step(1, 32'h0);
    idle();
    repeat (3) step();
    do_reset();
    repeat (2048) step();
    chk("mid_clear_cnt", 0, b0.ram_ready, 0);
    do_reset();
    wait_ready("restart_clear_len", 4096);
    ren = 1; radr = 12'h7FF;
    step(1, 32'h0);
    idle();
    repeat (3) step();
    chk("drain0", 0, sbq[0].size(), 0);
    chk("drain1", 1, sbq[1].size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
